arm_pipelined_hazard_controller: RTL and testbench

Central hazard scheduler for the 5-stage ARM pipelined datapath (F/D/E/M/W).
- Generates operand forwarding selects for the E-stage ALU input muxes.
- Generates per-stage stall and flush enables for the pipeline registers.
- Runs a data-memory wait/timeout state machine that freezes the pipeline while the M-stage memory access is not ready.

---
 rtl/arm_pipelined_hazard_controller.sv | 143 ++++++++++++++
 tb/tb_arm_pipelined_hazard_controller.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_pipelined_hazard_controller.sv
// Hazard scheduler for the 5-stage ARM pipeline: E-stage forwarding, stall/flush control, data-memory wait FSM.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_COUNT_EN.
module arm_pipelined_hazard_controller #(
    parameter int RegAddrWidth  = 4,
    parameter int TimeoutCycles = 255,
    parameter int CountWidth    = 8
) (
    input  logic                    i_CLK,
    input  logic                    i_RESET,
    input  logic [RegAddrWidth-1:0] i_RA1D,
    input  logic [RegAddrWidth-1:0] i_RA2D,
    input  logic [RegAddrWidth-1:0] i_RA1E,
    input  logic [RegAddrWidth-1:0] i_RA2E,
    input  logic [RegAddrWidth-1:0] i_WA3E,
    input  logic [RegAddrWidth-1:0] i_WA3M,
    input  logic [RegAddrWidth-1:0] i_WA3W,
    input  logic                    i_RegWriteE,
    input  logic                    i_RegWriteM,
    input  logic                    i_RegWriteW,
    input  logic                    i_MemtoRegE,
    input  logic                    i_BranchTakenE,
    input  logic                    i_MemReqM,
    input  logic                    i_MemReadyM,
    output logic [1:0]              o_ForwardAE,
    output logic [1:0]              o_ForwardBE,
    output logic                    o_StallF,
    output logic                    o_StallD,
    output logic                    o_StallE,
    output logic                    o_StallM,
    output logic                    o_FlushD,
    output logic                    o_FlushE,
    output logic                    o_MemBusy,
    output logic                    o_MemTimeout,
    output logic [15:0]             o_StallCycles
);

    // State | meaning
    // IDLE  | no outstanding slow memory access
    // WAIT  | M-stage access pending, pipeline frozen, counting toward timeout
    // ERR   | access timed out; pipeline frozen until reset
    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    localparam logic [RegAddrWidth-1:0] PcReg = '1;

    state_t                state;
    logic [CountWidth-1:0] count;
    logic                  timeout;
    logic                  mem_stall;
    logic                  load_use;
    logic                  any_stall;

    // The E-stage write enable is not needed: a load in E always implies a pending write.
    logic unused_regwrite_e;
    assign unused_regwrite_e = i_RegWriteE;

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state   <= IDLE;
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_MemReqM && !i_MemReadyM) begin
                        state <= WAIT;
                        count <= CountWidth'(1);
                    end
                end
                WAIT: begin
                    if (i_MemReadyM) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count == CountWidth'(TimeoutCycles)) begin
                        state   <= ERR;
                        timeout <= 1'b1;
                    end else begin
                        count <= count + CountWidth'(1);
                    end
                end
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [RegAddrWidth-1:0] ra);
        if (ra == PcReg)                      return 2'b00;
        else if (i_RegWriteM && i_WA3M == ra) return 2'b10;
        else if (i_RegWriteW && i_WA3W == ra) return 2'b01;
        else                                  return 2'b00;
    endfunction

    always_comb begin
        mem_stall = (state == WAIT) || (state == ERR) ||
                    (state == IDLE && i_MemReqM && !i_MemReadyM);
        load_use  = i_MemtoRegE &&
                    ((i_WA3E == i_RA1D && i_RA1D != PcReg) ||
                     (i_WA3E == i_RA2D && i_RA2D != PcReg));

        o_ForwardAE = 2'b00;
        o_ForwardBE = 2'b00;
        o_StallF    = 1'b0;
        o_StallD    = 1'b0;
        o_StallE    = 1'b0;
        o_StallM    = 1'b0;
        o_FlushD    = 1'b1;
        o_FlushE    = 1'b1;
        o_MemBusy   = 1'b0;
        // Reset forces a bubble everywhere, even before the first clock edge.
        if (!i_RESET) begin
            o_ForwardAE = fwd_sel(i_RA1E);
            o_ForwardBE = fwd_sel(i_RA2E);
            o_StallF    = mem_stall || (load_use && !i_BranchTakenE);
            o_StallD    = o_StallF;
            o_StallE    = mem_stall;
            o_StallM    = mem_stall;
            o_FlushD    = !mem_stall && i_BranchTakenE;
            o_FlushE    = !mem_stall && (i_BranchTakenE || load_use);
            o_MemBusy   = (state == WAIT);
        end
    end

    assign o_MemTimeout = timeout;
    assign any_stall    = o_StallF || o_StallD || o_StallE || o_StallM;

`ifdef HAZARD_PERF_COUNT_EN
    logic [15:0] stall_cycles;

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET)
            stall_cycles <= 16'h0000;
        else if (any_stall && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'h0001;
    end

    assign o_StallCycles = stall_cycles;
`else
    logic unused_any_stall;
    assign unused_any_stall = any_stall;
    assign o_StallCycles    = 16'h0000;
`endif

endmodule

// File: tb/tb_arm_pipelined_hazard_controller.sv
// Self-checking bench for arm_pipelined_hazard_controller: directed scenarios plus randomized run against a behavioural model.
// Honours HAZARD_PERF_COUNT_EN for the expected stall-cycle count.
module tb_arm_pipelined_hazard_controller;

    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       rwe, rwm, rww, memtoreg, br, req, ready;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, busy, tmo;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // behavioural model of the memory handshake and the perf counter
    bit m_busy, m_err;
    int m_wait, m_perf;

    always #5 clk = ~clk;

    arm_pipelined_hazard_controller #(
        .RegAddrWidth(4), .TimeoutCycles(TIMEOUT), .CountWidth(8)
    ) dut (
        .i_CLK(clk), .i_RESET(rst),
        .i_RA1D(ra1d), .i_RA2D(ra2d), .i_RA1E(ra1e), .i_RA2E(ra2e),
        .i_WA3E(wa3e), .i_WA3M(wa3m), .i_WA3W(wa3w),
        .i_RegWriteE(rwe), .i_RegWriteM(rwm), .i_RegWriteW(rww),
        .i_MemtoRegE(memtoreg), .i_BranchTakenE(br),
        .i_MemReqM(req), .i_MemReadyM(ready),
        .o_ForwardAE(fwd_a), .o_ForwardBE(fwd_b),
        .o_StallF(stall_f), .o_StallD(stall_d), .o_StallE(stall_e), .o_StallM(stall_m),
        .o_FlushD(flush_d), .o_FlushE(flush_e),
        .o_MemBusy(busy), .o_MemTimeout(tmo), .o_StallCycles(stall_cycles)
    );

    function automatic logic [1:0] exp_fwd(input logic [3:0] ra);
        if (ra == 4'd15) return 2'd0;
        if (rwm && wa3m == ra) return 2'd2;
        if (rww && wa3w == ra) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit exp_lu();
        return memtoreg && ((wa3e == ra1d && ra1d != 4'd15) || (wa3e == ra2d && ra2d != 4'd15));
    endfunction

    function automatic bit exp_ms();
        return m_err || m_busy || (req && !ready);
    endfunction

    task automatic clear_inputs();
        {ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w} = '0;
        {rwe, rwm, rww, memtoreg, br, req, ready} = '0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_wait = 0; m_perf = 0;
    endtask

    task automatic model_clock();
        bit ms, st;
        ms = exp_ms();
        st = ms || (exp_lu() && !br);
        if (st && m_perf < 65535) m_perf++;
        if (!m_err) begin
            if (!m_busy) begin
                if (req && !ready) begin m_busy = 1; m_wait = 1; end
            end else if (ready) m_busy = 0;
            else if (m_wait == TIMEOUT) begin m_err = 1; m_busy = 0; end
            else m_wait++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            {ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w} = 28'($urandom);
            {rwe, rwm, rww, memtoreg, br, req, ready} = 7'($urandom);
            #3;
            checks++;
            if ({fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, busy, tmo} !== 12'b0000_0000_1100) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %b required 000000001100", i,
                         {fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, busy, tmo});
            end
            checks++;
            if (stall_cycles !== 16'h0) begin
                errors++;
                $display("FAIL reset_stall_cycles: got %0h required 0", stall_cycles);
            end
            @(posedge clk);
        end
        do_reset();
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        wa3m = 3; rwm = 1; wa3w = 3; rww = 1; ra1e = 3; ra2e = 3;
        #1;
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            errors++; $display("FAIL fwd_m_priority: got A=%b B=%b required 10", fwd_a, fwd_b);
        end
        rwm = 0; #1;
        checks++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            errors++; $display("FAIL fwd_w: got A=%b B=%b required 01", fwd_a, fwd_b);
        end
        rwm = 1; wa3m = 15; wa3w = 15; ra1e = 15; ra2e = 15; #1;
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++; $display("FAIL fwd_r15: got A=%b B=%b required 00", fwd_a, fwd_b);
        end
        ra1e = 15; ra2e = 3; wa3m = 15; wa3w = 3; #1;
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b01) begin
            errors++; $display("FAIL fwd_mixed: got A=%b B=%b required A=00 B=01", fwd_a, fwd_b);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        memtoreg = 1; wa3e = 5; ra2d = 5; ra1d = 0; #1;
        checks++;
        if ({stall_f, stall_d, stall_e, flush_d, flush_e} !== 5'b11001) begin
            errors++; $display("FAIL load_use: got F,D,E,flD,flE=%b required 11001",
                               {stall_f, stall_d, stall_e, flush_d, flush_e});
        end
        @(negedge clk);
        memtoreg = 0; #1;
        checks++;
        if ({stall_f, stall_d, flush_e} !== 3'b000) begin
            errors++; $display("FAIL load_use_release: got %b required 000", {stall_f, stall_d, flush_e});
        end
        memtoreg = 1; wa3e = 15; ra1d = 15; ra2d = 15; #1;
        checks++;
        if ({stall_f, flush_e} !== 2'b00) begin
            errors++; $display("FAIL load_use_r15: got %b required 00", {stall_f, flush_e});
        end
        memtoreg = 1; wa3e = 5; ra2d = 5; ra1d = 0; br = 1; #1;
        checks++;
        if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
            errors++; $display("FAIL branch_over_lu: got F,D,flD,flE=%b required 0011",
                               {stall_f, stall_d, flush_d, flush_e});
        end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        logic [15:0] perf_exp;
        do_reset();
        req = 1; ready = 0; br = 1;
        for (int k = 0; k < 4; k++) begin
            ready = (k == 3);
            #1;
            checks++;
            if ({busy, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e} !== {(k > 0), 6'b111100}) begin
                errors++; $display("FAIL mem_wait[%0d]: got busy,stalls,flushes=%b required %b", k,
                                   {busy, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}, {(k > 0), 6'b111100});
            end
            @(negedge clk);
        end
        req = 0; ready = 0; #1;
        checks++;
        if ({busy, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e} !== 7'b0000011) begin
            errors++; $display("FAIL mem_release: got %b required 0000011",
                               {busy, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e});
        end
`ifdef HAZARD_PERF_COUNT_EN
        perf_exp = 16'd4;
`else
        perf_exp = 16'd0;
`endif
        checks++;
        if (stall_cycles !== perf_exp) begin
            errors++; $display("FAIL mem_stall_cycles: got %0d required %0d", stall_cycles, perf_exp);
        end
        // a single-cycle ready access must not stall
        br = 0; req = 1; ready = 1; #1;
        checks++;
        if (stall_f !== 1'b0 || stall_m !== 1'b0) begin
            errors++; $display("FAIL mem_fast_access: got F=%b M=%b required 0", stall_f, stall_m);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 1; ready = 0;
        for (int k = 0; k <= TIMEOUT; k++) begin
            #1;
            checks++;
            if ({busy, tmo, stall_f, stall_m} !== {(k >= 1), 3'b011}) begin
                errors++; $display("FAIL timeout_wait[%0d]: got busy,tmo,F,M=%b required %b", k,
                                   {busy, tmo, stall_f, stall_m}, {(k >= 1), 3'b011});
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({busy, tmo, stall_f, stall_d, stall_e, stall_m} !== 6'b011111) begin
            errors++; $display("FAIL timeout_err: got %b required 011111", {busy, tmo, stall_f, stall_d, stall_e, stall_m});
        end
        ready = 1;
        repeat (3) @(negedge clk);
        req = 0; #1;
        checks++;
        if ({busy, tmo, stall_f, stall_m, flush_d} !== 5'b01110) begin
            errors++; $display("FAIL timeout_sticky: got %b required 01110", {busy, tmo, stall_f, stall_m, flush_d});
        end
        rst = 1; #1;
        checks++;
        if ({tmo, stall_f, stall_m, flush_d, flush_e} !== 5'b00011) begin
            errors++; $display("FAIL timeout_reset: got %b required 00011", {tmo, stall_f, stall_m, flush_d, flush_e});
        end
        @(negedge clk);
        rst = 0; clear_inputs(); #1;
        checks++;
        if ({tmo, stall_f, stall_m} !== 3'b000) begin
            errors++; $display("FAIL timeout_after_reset: got %b required 000", {tmo, stall_f, stall_m});
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        req = 1; ready = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_wait_setup: got busy=%b required 1", busy);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({busy, flush_d, flush_e, stall_f, stall_m} !== 5'b01100) begin
            errors++; $display("FAIL async_reset_mid_wait: got %b required 01100", {busy, flush_d, flush_e, stall_f, stall_m});
        end
        @(negedge clk);
        req = 0; rst = 0;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, stall_f, stall_e, stall_m} !== 4'b0000) begin
            errors++; $display("FAIL after_mid_wait_reset: got %b required 0000", {busy, stall_f, stall_e, stall_m});
        end
    endtask

    function automatic logic [3:0] rand_reg();
        return ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic [11:0] got, exp;
        logic [15:0] perf_exp;
        bit ms, lu;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ra1d = rand_reg(); ra2d = rand_reg(); ra1e = rand_reg(); ra2e = rand_reg();
            wa3e = rand_reg(); wa3m = rand_reg(); wa3w = rand_reg();
            rwe = 1'($urandom); rwm = 1'($urandom); rww = 1'($urandom);
            memtoreg = 1'($urandom); br = ($urandom_range(0, 3) == 0);
            req = ($urandom_range(0, 9) < 3);
            ready = (m_busy && m_wait >= TIMEOUT - 1) ? 1'b1 : 1'($urandom);
            #1;
            ms = exp_ms();
            lu = exp_lu();
            exp = {exp_fwd(ra1e), exp_fwd(ra2e),
                   ms || (lu && !br), ms || (lu && !br), ms, ms,
                   !ms && br, !ms && (br || lu), m_busy, m_err};
            got = {fwd_a, fwd_b, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, busy, tmo};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random[%0d]: got %b required %b", n, got, exp);
            end
`ifdef HAZARD_PERF_COUNT_EN
            perf_exp = 16'(m_perf);
`else
            perf_exp = 16'd0;
`endif
            checks++;
            if (stall_cycles !== perf_exp) begin
                errors++; $display("FAIL random_stall_cycles[%0d]: got %0d required %0d", n, stall_cycles, perf_exp);
            end
            @(posedge clk);
            model_clock();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_reset();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
